// File: rtl/prog_loader.sv
// prog_loader: byte-serial program loader feeding the n1 core's instruction RAM.
// Frame: 0xA5 (SYNC), START, COUNT, then COUNT big-endian 16-bit words.
// Optional build macro PROG_LOADER_CHECKSUM_EN appends an XOR checksum byte
// covering START, COUNT and every data byte.
module prog_loader #(
    parameter  int RAM_WORDS = 128,
    localparam int ADDR_BITS = $clog2(RAM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [ADDR_BITS-1:0] addr_q;
    logic [7:0]           cnt_q;
    logic [7:0]           hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]           csum_q;
`endif

    logic take;
    logic is_sync;
    logic cnt_bad;

    // A byte moves only when the registered ready and the source valid coincide.
    assign take    = en && in_valid && in_ready;
    assign is_sync = (in_data == SYNC_BYTE);
    assign cnt_bad = (in_data == 8'd0) || ({24'd0, in_data} > RAM_WORDS);

    assign mem_addr = addr_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state decode; dropping en overrides everything and parks the loader in IDLE.
    always_comb begin
        // NOTE: default assigned first so every path drives next_state and no latch is inferred.
        next_state = state;
        if (!en) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: if (take && is_sync) next_state = ST_ADDR;
                ST_ADDR:  if (take) next_state = ST_CNT;
                ST_CNT:   if (take) next_state = cnt_bad ? ST_ERR : ST_HI;
                ST_HI:    if (take) next_state = ST_LO;
                ST_LO:    if (take) next_state = ST_WRITE;
                ST_WRITE: begin
                    if (cnt_q != 8'd1) begin
                        next_state = ST_HI;
                    end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        next_state = ST_CSUM;
`else
                        next_state = ST_DONE;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CSUM:  if (take) next_state = (in_data == csum_q) ? ST_DONE : ST_ERR;
`endif
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    // Registered outputs decoded from the state being entered, so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= en && (next_state != ST_WRITE);
            mem_we   <= (next_state == ST_WRITE);
            busy     <= !(next_state inside {ST_IDLE, ST_DONE, ST_ERR});
            done     <= (next_state == ST_DONE);
            err      <= (next_state == ST_ERR);
        end
    end

    // Frame datapath: address/count/byte capture, write data, running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            cnt_q     <= 8'd0;
            hi_q      <= 8'd0;
            mem_wdata <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q    <= 8'd0;
`endif
        end else if (en) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (take && is_sync) csum_q <= 8'd0;
`endif
                end
                ST_ADDR: if (take) begin
                    // Only the low ADDR_BITS bits of START select the first word.
                    addr_q <= ADDR_BITS'(in_data);
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ in_data;
`endif
                end
                ST_CNT: if (take) begin
                    cnt_q <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ in_data;
`endif
                end
                ST_HI: if (take) begin
                    hi_q <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ in_data;
`endif
                end
                ST_LO: if (take) begin
                    mem_wdata <= {hi_q, in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ in_data;
`endif
                end
                ST_WRITE: begin
                    // Power-of-two depth: the address wraps naturally at RAM_WORDS.
                    addr_q <= addr_q + ADDR_BITS'(1);
                    cnt_q  <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed stimulus for prog_loader, checked
// against a frame-level model that derives expected RAM writes and final
// status from the frame bytes alone.
module tb_prog_loader;

    localparam int RAM_WORDS = 128;
    localparam int AW        = $clog2(RAM_WORDS);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'd0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];
    bit   tag_lo = 1'b0;
    logic [15:0] shadow [RAM_WORDS];
    int   n_writes = 0;

    prog_loader #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // XOR over every byte after SYNC; used to build frames carrying a checksum.
    function automatic logic [7:0] xsum(input logic [7:0] q[$]);
        logic [7:0] x = 8'd0;
        for (int i = 1; i < q.size(); i++) x ^= q[i];
        return x;
    endfunction

    // Per-cycle compare: a write must follow exactly one cycle after each low
    // byte is accepted, and must match the next expected (addr, data).
    initial begin : compare
        bit  exp_we;
        wr_t e;
        exp_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_we = 1'b0;
            end else begin
                check("mem_we_timing", mem_we, exp_we);
                if (mem_we) begin
                    check("ready_low_in_write", in_ready, 0);
                    shadow[mem_addr] = mem_wdata;
                    n_writes++;
                    check("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                    end
                end
                check("done_err_exclusive", done & err, 0);
                check("busy_done_exclusive", busy & done, 0);
                exp_we = en && in_valid && in_ready && tag_lo;
            end
        end
    end

    // Present one byte and hold it until accepted. Called at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit lo, input bit gaps);
        int waited;
        bit accepted;
        waited   = 0;
        accepted = 1'b0;
        if (gaps) begin
            in_valid = 1'b0;
            tag_lo   = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        tag_lo   = lo;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
            end else begin
                waited++;
            end
        end
        check("byte_accepted", accepted, 1);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        tag_lo   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame-level model plus driver. csum_byte < 0 appends the correct checksum.
    task automatic run_frame(input logic [7:0] frame[$], input bit gaps,
                             input int csum_byte, output bit ok);
        logic [7:0] fr[$];
        int         start;
        int         n;
        bit         cnt_ok;
        wr_t        w;
        fr     = frame;
        start  = int'(fr[1]) % RAM_WORDS;
        n      = int'(fr[2]);
        cnt_ok = (n >= 1) && (n <= RAM_WORDS);
        ok     = cnt_ok;
        if (cnt_ok) begin
            for (int i = 0; i < n; i++) begin
                w.addr = AW'((start + i) % RAM_WORDS);
                w.data = {fr[3 + 2 * i], fr[4 + 2 * i]};
                exp_q.push_back(w);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (cnt_ok) begin
            logic [7:0] x;
            logic [7:0] c;
            x = 8'd0;
            for (int j = 1; j < 3 + 2 * n; j++) x = x ^ fr[j];
            c = (csum_byte < 0) ? xsum(fr) : 8'(csum_byte);
            fr.push_back(c);
            ok = (c == x);
        end
`else
        if (csum_byte > 255) ok = 1'b0;
`endif
        for (int j = 0; j < fr.size(); j++) begin
            send_byte(fr[j], cnt_ok && (j >= 3) && (j < 3 + 2 * n) && ((j - 3) % 2 == 1), gaps);
        end
        idle_cycles(3);
        check("frame_done", done, ok);
        check("frame_err", err, !ok);
        check("frame_busy", busy, 0);
        check("frame_writes_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [7:0] fr[$];
        bit         ok;
        int         w0;
        int         n;
        logic [7:0] nb;

        // Reset values.
        en    = 1'b1;
        rst_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);

        // Basic load.
        w0 = n_writes;
        fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h05, 8'h40, 8'h10};
        run_frame(fr, 1'b0, -1, ok);
        check("basic_nwrites", n_writes - w0, 2);
        check("basic_addr0", shadow[0], 16'h1205);
        check("basic_addr1", shadow[1], 16'h4010);
        check("basic_done", done, 1);

        // Wrap-around 127 -> 0.
        fr = {8'hA5, 8'h7F, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
        run_frame(fr, 1'b1, -1, ok);
        check("wrap_addr127", shadow[127], 16'h1111);
        check("wrap_addr0", shadow[0], 16'h2222);

        // Noise then zero count; then a good frame clears err.
        w0 = n_writes;
        send_byte(8'h33, 1'b0, 1'b0);
        fr = {8'hA5, 8'h00, 8'h00};
        run_frame(fr, 1'b0, -1, ok);
        check("zero_cnt_err", err, 1);
        check("zero_cnt_nwrites", n_writes - w0, 0);
        fr = {8'hA5, 8'h00, 8'h01, 8'h50, 8'h00};
        run_frame(fr, 1'b0, -1, ok);
        check("recover_addr0", shadow[0], 16'h5000);
        check("recover_done", done, 1);

        // Count just above depth is rejected; count equal to depth loads.
        fr = {8'hA5, 8'h00, 8'(RAM_WORDS + 1)};
        run_frame(fr, 1'b1, -1, ok);
        check("over_cnt_err", err, 1);
        w0 = n_writes;
        fr = {8'hA5, 8'h85, 8'(RAM_WORDS)};
        for (int i = 0; i < 2 * RAM_WORDS; i++) fr.push_back(8'($urandom));
        run_frame(fr, 1'b0, -1, ok);
        check("full_nwrites", n_writes - w0, RAM_WORDS);

        // Back-to-back valid through a 3-word frame.
        w0 = n_writes;
        fr = {8'hA5, 8'h10, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        run_frame(fr, 1'b0, -1, ok);
        check("bp_nwrites", n_writes - w0, 3);
        check("bp_word2", shadow[18], 16'h0102);

        // Abort after the first high byte.
        w0 = n_writes;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        in_valid = 1'b0;
        en       = 1'b0;
        idle_cycles(3);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_ready", in_ready, 0);
        check("abort_nwrites", n_writes - w0, 0);
        en = 1'b1;
        idle_cycles(1);
        fr = {8'hA5, 8'h20, 8'h01, 8'h77, 8'h66};
        run_frame(fr, 1'b1, -1, ok);
        check("abort_reload", shadow[32], 16'h7766);

        // Asynchronous reset mid-frame.
        w0 = n_writes;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", in_ready, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);
        check("arst_nwrites", n_writes - w0, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        fr = {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
        check("csum_pin", xsum(fr), 8'h27);
        run_frame(fr, 1'b0, 8'h27, ok);
        check("csum_good_done", done, 1);
        run_frame(fr, 1'b0, 8'h00, ok);
        check("csum_bad_err", err, 1);
        check("csum_bad_written", shadow[0], 16'h1234);
`endif

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb, 1'b0, 1'b1);
            end
            if ($urandom_range(0, 5) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(RAM_WORDS + 1, 255);
            end else begin
                n = $urandom_range(1, 6);
            end
            fr = {8'hA5, 8'($urandom_range(0, 255)), 8'(n)};
            if (n >= 1 && n <= RAM_WORDS) begin
                for (int i = 0; i < 2 * n; i++) fr.push_back(8'($urandom));
            end
            run_frame(fr, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1, ok);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-serial program loader that sits directly upstream of the n1 core's instruction RAM. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes each word to the RAM write port at auto-incrementing addresses. The core is held in reset while the loader is enabled; once `done` is asserted, the core is released and runs the loaded program from PC 0.

Parameters:
- RAM_WORDS, 128, depth of the instruction RAM in 16-bit words. Must be a power of 2.
- ADDR_BITS, $clog2(RAM_WORDS), width of the RAM word address (derived localparam, not overridable).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  loader enable. Low forces IDLE and clears status.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  RAM write strobe, one-cycle pulse.
- mem_addr  out  ADDR_BITS  RAM word address.
- mem_wdata  out  16  RAM write data.
- busy  out  1  a frame is in progress (state is neither IDLE, DONE nor ERR).
- done  out  1  last frame completed successfully (sticky).
- err  out  1  last frame was rejected (sticky).

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0; state=IDLE.
- Byte transfer: a byte is accepted on a rising edge where in_valid && in_ready. All outputs are registered.
- Frame format: SYNC (0xA5), START (low ADDR_BITS bits = first word address; upper bits ignored), COUNT (N words), then 2N data bytes, high byte first. With CHECKSUM_EN, a checksum byte follows the data.
- States: IDLE, ADDR, CNT, HI, LO, WRITE, [CSUM], DONE, ERR.
- IDLE: in_ready=1 when en=1. A non-0xA5 byte is consumed and discarded. Accepting 0xA5 goes to ADDR and clears done/err.
- ADDR: latch the start address, go to CNT.
- CNT: N=0 or N>RAM_WORDS goes to ERR. Otherwise latch N and go to HI.
- HI: latch the high byte, go to LO.
- LO: latch the low byte, go to WRITE.
- WRITE: in_ready=0. mem_we=1 for exactly this cycle, with mem_addr = current address and mem_wdata = {hi, lo}. Then increment the address modulo RAM_WORDS (127 -> 0 for default) and decrement the remaining count. If the remaining count is nonzero, go to HI; otherwise go to DONE (or CSUM when compiled in).
- Latency: the low byte accepted at edge k produces mem_we high in the cycle after edge k. The next data byte can be accepted no earlier than edge k+2.
- DONE: done=1, in_ready=1. Accepting 0xA5 starts a new frame (done cleared). Other bytes are discarded.
- ERR: err=1. Same byte handling as DONE.
- No mem_we ever occurs outside WRITE.
- en=0 at any time: next state is IDLE, and done, err, busy and in_ready drop on the next edge. A pending WRITE still completes that cycle if already entered; no later writes occur.
- Async reset mid-frame: all state and outputs return immediately to reset values.
- in_valid while in_ready=0: the byte is not consumed. The upstream source must hold it.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR is kept over START, COUNT and all data bytes, cleared on SYNC.
  - After the last WRITE the state goes to CSUM (in_ready=1).
  - On the received byte: equal to the running XOR goes to DONE; otherwise goes to ERR.
  - Words already written remain in RAM; err flags the frame as untrusted.
- Undefined: no CSUM state and no XOR register; the last WRITE goes straight to DONE.

Test Plan:
- Basic load, en=1: bytes A5,00,02,12,05,40,10 -> two mem_we pulses: addr0=0x1205, addr1=0x4010. done=1 and busy=0 one cycle after the second pulse.
- Wrap-around: A5,7F,02,11,11,22,22 -> writes addr127=0x1111, then addr0=0x2222. done=1.
- Noise and bad count:
  - 33,A5,00,00 -> 0x33 discarded, no writes, err=1.
  - A second frame A5,00,01,50,00 -> err cleared on SYNC, addr0=0x5000 written, done=1.
- Backpressure: hold in_valid=1 continuously through a 3-word frame -> in_ready=0 in each WRITE cycle, no byte lost or duplicated, exactly 3 mem_we pulses.
- Abort: drop en after the first data word's high byte -> no mem_we, busy=0, done=0, err=0. Re-asserting en and sending a full frame loads correctly.
- PROG_LOADER_CHECKSUM_EN:
  - A5,00,01,12,34 then checksum 0x27 (00^01^12^34) -> done=1.
  - The same frame with checksum 0x00 -> addr0=0x1234 still written, err=1.
